// File: rtl/uart_pkg.sv
// uart_pkg: receiver FSM states and bit-timing helpers shared by the UART receive path.
`timescale 1ns/1ps
package uart_pkg;
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;
    function automatic int clks_per_bit(input int clk_hz, input int baud);
        return clk_hz / baud;
    endfunction
    function automatic int half_bit(input int clk_hz, input int baud);
        return clks_per_bit(clk_hz, baud) / 2;
    endfunction
endpackage

// File: rtl/rx_fifo.sv
// rx_fifo: show-ahead byte FIFO; a pop frees a slot for a push in the same cycle.
`timescale 1ns/1ps
module rx_fifo #(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       push_i,
    input  logic [7:0] data_i,
    input  logic       pop_i,
    output logic [7:0] data_o,
    output logic       full_o,
    output logic       empty_o,
    output logic       drop_o
);
    localparam int AW = $clog2(DEPTH);
    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] rd_q, wr_q;
    logic [AW:0]   cnt_q;
    logic          do_push, do_pop;
    always_comb begin
        empty_o = cnt_q == '0;
        full_o  = cnt_q == (AW+1)'(DEPTH);
        do_pop  = pop_i && !empty_o;
        do_push = push_i && (!full_o || do_pop);
        drop_o  = push_i && full_o && !pop_i;
        data_o  = empty_o ? 8'h00 : mem_q[rd_q];
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_push) wr_q <= wr_q + 1'b1;
            if (do_pop) rd_q <= rd_q + 1'b1;
            cnt_q <= cnt_q + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
        end
    end
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q] <= data_i;
    end
endmodule

// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver with 2-flop input synchronizer, mid-bit sampling FSM
// and a show-ahead receive FIFO.
`timescale 1ns/1ps
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLK_FREQ_HZ = 25000000,
    parameter int BAUD_RATE   = 115200,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rxd,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       frame_err,
    output logic       overrun,
    output logic       busy
);
    localparam int CLKS_PER_BIT = clks_per_bit(CLK_FREQ_HZ, BAUD_RATE);
    localparam int HALF_BIT     = half_bit(CLK_FREQ_HZ, BAUD_RATE);
    localparam int CW           = $clog2(CLKS_PER_BIT + 1);
    localparam logic [CW-1:0] BIT_END  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_END = CW'(HALF_BIT - 1);
    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic          rxd_meta_q, rxd_sync_q, rxd_prev_q;
    logic          frame_err_q, overrun_q;
    logic          fall, push, ferr, empty, full, drop;
    // Edge detect on the synchronized line; a low line after a framing error needs a high first.
    assign fall = rxd_prev_q && !rxd_sync_q;
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CW'(1);
        bit_d   = bit_q;
        shift_d = shift_q;
        push    = 1'b0;
        ferr    = 1'b0;
        unique case (state_q)
            IDLE: begin
                cnt_d   = '0;
                bit_d   = '0;
                state_d = fall ? START : IDLE;
            end
            START: if (cnt_q == HALF_END) begin
                cnt_d   = '0;
                state_d = rxd_sync_q ? IDLE : DATA;
            end
            DATA: if (cnt_q == BIT_END) begin
                cnt_d   = '0;
                shift_d = {rxd_sync_q, shift_q[7:1]};
                bit_d   = bit_q + 3'd1;
                state_d = bit_q == 3'd7 ? STOP : DATA;
            end
            STOP: if (cnt_q == BIT_END) begin
                cnt_d   = '0;
                push    = rxd_sync_q;
                ferr    = !rxd_sync_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            bit_q       <= '0;
            shift_q     <= '0;
            rxd_meta_q  <= 1'b1;
            rxd_sync_q  <= 1'b1;
            rxd_prev_q  <= 1'b1;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_q       <= bit_d;
            shift_q     <= shift_d;
            rxd_meta_q  <= rxd;
            rxd_sync_q  <= rxd_meta_q;
            rxd_prev_q  <= rxd_sync_q;
            frame_err_q <= ferr;
            overrun_q   <= drop;
        end
    end
    rx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk    (clk),
        .reset  (reset),
        .push_i (push),
        .data_i (shift_q),
        .pop_i  (rx_ready),
        .data_o (rx_data),
        .full_o (full),
        .empty_o(empty),
        .drop_o (drop)
    );
    assign rx_valid  = !empty;
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;
    assign busy      = state_q != IDLE;
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed frames at 25 MHz / 115200 baud with a byte scoreboard
// and pulse counters for frame_err and overrun.
`timescale 1ns/1ps
module tb_uart_rx;
    localparam int BIT_NS = 8680;
    localparam int CLK_NS = 40;
    localparam int HALF_BIT = 108;
    logic       clk = 1'b0, reset = 1'b1, rxd = 1'b1, rx_ready = 1'b0;
    logic [7:0] rx_data;
    logic       rx_valid, frame_err, overrun, busy;
    int         passed = 0, total = 0, fe_cnt = 0, ov_cnt = 0, exp_ov = 0, fe0 = 0, ov0 = 0, cyc = 0;
    logic [7:0] q[$];
    logic [7:0] burst [5] = '{8'h2A, 8'h34, 8'h39, 8'h2F, 8'h30};
    logic [7:0] fill  [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    logic [7:0] fbyte = 8'hF0;

    uart_rx dut (
        .clk      (clk),
        .reset    (reset),
        .rxd      (rxd),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_ready (rx_ready),
        .frame_err(frame_err),
        .overrun  (overrun),
        .busy     (busy)
    );

    always #(CLK_NS/2) clk = ~clk;

    always @(negedge clk) begin
        if (frame_err) fe_cnt++;
        if (overrun) ov_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Start edge is negedge-aligned; ready_cyc > 0 pops once in the clock whose
    // posedge samples the stop bit (3 sync/edge cycles + HALF_BIT + 9 bit periods).
    task automatic send_frame(input logic [7:0] b, input int ext, input logic stop, input int ready_cyc);
        @(negedge clk);
        rxd = 1'b0;
        #(BIT_NS + ext);
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            #(BIT_NS);
        end
        rxd = stop;
        if (ready_cyc > 0) begin
            #(ready_cyc * CLK_NS);
            check("head_at_pop", rx_data, q[0]);
            void'(q.pop_front());
            rx_ready = 1'b1;
            #(CLK_NS);
            rx_ready = 1'b0;
            #(BIT_NS - ready_cyc * CLK_NS - CLK_NS);
        end else begin
            #(BIT_NS);
        end
        rxd = 1'b1;
    endtask

    task automatic wait_valid(input string tag);
        for (int i = 0; i < 3000 && !rx_valid; i++) @(negedge clk);
        check(tag, rx_valid, 1);
    endtask

    task automatic pop_check(input string tag);
        logic [7:0] exp;
        exp = q.size() > 0 ? q.pop_front() : 8'hxx;
        @(negedge clk);
        check({tag, "_valid"}, rx_valid, 1);
        check({tag, "_data"}, rx_data, exp);
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        check("rst_valid", rx_valid, 0);
        check("rst_data", rx_data, 8'h00);
        check("rst_frame_err", frame_err, 0);
        check("rst_overrun", overrun, 0);
        check("rst_busy", busy, 0);
        reset = 1'b0;
        repeat (5) @(negedge clk);

        send_frame(8'h34, 1000, 1'b1, 0);
        q.push_back(8'h34);
        wait_valid("long_start_valid");
        check("long_start_no_ferr", fe_cnt, 0);
        pop_check("long_start");
        check("long_start_empty", rx_valid, 0);

        foreach (burst[i]) begin
            send_frame(burst[i], 0, 1'b1, 0);
            if (q.size() < 4) q.push_back(burst[i]);
            else exp_ov++;
        end
        repeat (10) @(negedge clk);
        check("burst_overrun_cnt", ov_cnt, exp_ov);
        check("burst_no_ferr", fe_cnt, 0);
        repeat (4) pop_check("burst");
        check("burst_drained", rx_valid, 0);

        fe0 = fe_cnt;
        send_frame(8'h55, 0, 1'b0, 0);
        #(BIT_NS);
        check("ferr_pulse_cnt", fe_cnt - fe0, 1);
        check("ferr_no_push", rx_valid, 0);
        send_frame(8'hA5, 0, 1'b1, 0);
        q.push_back(8'hA5);
        wait_valid("after_ferr_valid");
        check("after_ferr_data", rx_data, q[0]);
        check("after_ferr_no_new_ferr", fe_cnt - fe0, 1);

        // Reset in the middle of data bit 4 of 0xF0 while 0xA5 still sits in the FIFO.
        fe0 = fe_cnt;
        ov0 = ov_cnt;
        @(negedge clk);
        rxd = 1'b0;
        #(BIT_NS);
        for (int i = 0; i < 4; i++) begin
            rxd = fbyte[i];
            #(BIT_NS);
        end
        rxd = fbyte[4];
        #(BIT_NS / 2);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        q.delete();
        check("midrst_valid", rx_valid, 0);
        check("midrst_data", rx_data, 8'h00);
        check("midrst_frame_err", frame_err, 0);
        check("midrst_overrun", overrun, 0);
        check("midrst_busy", busy, 0);
        repeat (1500) @(negedge clk);
        check("midrst_no_push", rx_valid, 0);
        check("midrst_no_ferr", fe_cnt - fe0, 0);
        send_frame(8'h0F, 0, 1'b1, 0);
        q.push_back(8'h0F);
        wait_valid("midrst_next_valid");
        pop_check("midrst_next");

        fe0 = fe_cnt;
        @(negedge clk);
        rxd = 1'b0;
        repeat (5) @(negedge clk);
        check("glitch_busy_high", busy, 1);
        repeat (35) @(negedge clk);
        rxd = 1'b1;
        cyc = 40;
        while (busy && cyc < 400) begin
            @(negedge clk);
            cyc++;
        end
        check("glitch_busy_len", cyc >= HALF_BIT + 1 && cyc <= HALF_BIT + 6, 1);
        repeat (20) @(negedge clk);
        check("glitch_no_push", rx_valid, 0);
        check("glitch_no_ferr", fe_cnt - fe0, 0);

        ov0 = ov_cnt;
        foreach (fill[i]) begin
            send_frame(fill[i], 0, 1'b1, 0);
            q.push_back(fill[i]);
        end
        send_frame(8'h5A, 0, 1'b1, 110);
        q.push_back(8'h5A);
        repeat (5) @(negedge clk);
        check("full_pop_push_no_overrun", ov_cnt - ov0, 0);
        repeat (4) pop_check("full_pop_push");
        check("full_pop_push_drained", rx_valid, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter CLK_FREQ_HZ, default 25000000, system clock frequency.
REQ-002 SHALL have parameter BAUD_RATE, default 115200, serial bit rate.
REQ-003 SHALL have parameter FIFO_DEPTH, default 4, received-byte buffer entries (power of two, >=2).
REQ-004 SHALL have port clk  input  1  single system clock; all logic on rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port rxd  input  1  asynchronous serial line; idles high.
REQ-007 SHALL have port rx_data  output  8  byte at FIFO head (show-ahead).
REQ-008 SHALL have port rx_valid  output  1  FIFO non-empty.
REQ-009 SHALL have port rx_ready  input  1  consumer accepts head byte.
REQ-010 SHALL have port frame_err  output  1  one-cycle pulse on a bad stop bit.
REQ-011 SHALL have port overrun  output  1  one-cycle pulse when a byte is dropped because the FIFO is full.
REQ-012 SHALL have port busy  output  1  high whenever the FSM is not IDLE.

Function
REQ-013 SHALL define CLKS_PER_BIT = CLK_FREQ_HZ / BAUD_RATE (integer division, 217 at defaults) and HALF_BIT = CLKS_PER_BIT / 2 (108).
REQ-014 SHALL pass rxd through a 2-flop synchronizer; all FSM decisions use the synchronized value only.
REQ-015 SHALL implement FSM states IDLE, START, DATA, STOP.
REQ-016 IDLE: a synchronized high->low transition SHALL go to START and clear the bit-period counter.
REQ-017 START: after HALF_BIT cycles, sample the line; low -> go to DATA and clear the counter; high -> glitch, return to IDLE with no other effect.
REQ-018 DATA: sample every CLKS_PER_BIT cycles, shift LSB first; after the 8th sample go to STOP.
REQ-019 STOP: after CLKS_PER_BIT cycles, sample the line. High -> push the byte. Low -> pulse frame_err and discard the byte. Either way, return to IDLE the same cycle.
REQ-020 In IDLE after a framing error, a new start SHALL be accepted only after a falling edge, i.e. the line must first be seen high.
REQ-021 Push latency: rx_valid SHALL be high on the cycle after the stop-bit sample when the FIFO was empty.
REQ-022 Pop SHALL occur on rx_valid && rx_ready; rx_data SHALL show the next entry on the following cycle.
REQ-023 Push into a full FIFO without a simultaneous pop SHALL drop the new byte, leave contents unchanged and pulse overrun.
REQ-024 Simultaneous push and pop when full SHALL pop then push: no overrun, and the count stays FIFO_DEPTH.
REQ-025 Simultaneous push and pop when empty SHALL not pop; the pushed byte appears with rx_valid next cycle.
REQ-026 Read and write pointers SHALL wrap modulo FIFO_DEPTH; the count is held in log2(FIFO_DEPTH)+1 bits.
REQ-027 Sampling error tolerance: a start bit lengthened by up to 25 clk cycles SHALL still be received correctly.

Reset
REQ-028 On reset the FSM SHALL enter IDLE, counters and shift register clear, and synchronizer flops load 1.
REQ-029 On reset the FIFO SHALL empty; rx_valid, frame_err, overrun and busy SHALL be 0, and rx_data SHALL be 8'h00.
REQ-030 Reset mid-frame SHALL abandon the frame without push or error pulse; reception SHALL resume at the next falling edge.

Structure
REQ-031 Package uart_pkg SHALL hold the FSM state enum and the CLKS_PER_BIT / HALF_BIT computation as a constant function.
REQ-032 The FIFO SHALL be sub-module rx_fifo (parameter DEPTH, width 8, show-ahead, push/pop/full/empty); the FSM and synchronizer stay in uart_rx.

Verification
REQ-033 Defaults; send 8'h34 at 8680 ns/bit with a 1000 ns extended start bit -> rx_valid rises with rx_data=8'h34, and no frame_err.
REQ-034 Send 8'h2A, 8'h34, 8'h39, 8'h2F, 8'h30 back-to-back with rx_ready=0 -> first four bytes are held in order, 5th pulses overrun; after draining, reads are 2A,34,39,2F.
REQ-035 Send 8'h55 with the stop bit forced low -> frame_err pulses once, rx_valid stays 0, and the next byte 8'hA5 is received correctly.
REQ-036 A 40-cycle low glitch on idle rxd -> returns to IDLE; busy deasserts after ~HALF_BIT+3 cycles; no push and no error.
REQ-037 Assert reset at data bit 4 of 8'hF0 -> all outputs 0 the next cycle; a subsequent 8'h0F is received correctly.
REQ-038 FIFO full with rx_ready=1 on the stop-sample cycle -> no overrun; the count stays 4; the oldest byte is removed.
